// File: rtl/usart_pkg.sv
// Shared types and defaults for the USART transmit scheduler.
package usart_pkg;

    localparam int BYTE_W         = 8;
    localparam int GID_W          = 3;
    localparam int DEF_NREQ       = 4;
    localparam int DEF_GAP_CYCLES = 2;
    localparam int DEF_TIMEOUT    = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: the first pending request at or after ptr wins.
module rr_arbiter
    import usart_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]  req,
    input  logic [GID_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [GID_W-1:0] index,
    output logic             any
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    function automatic int rr_pos(input int base, input int off);
        int s;
        s = base + off;
        return (s >= NREQ) ? s - NREQ : s;
    endfunction

    logic [IW-1:0] pos;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = IW'(rr_pos(int'(ptr), k));
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                index      = GID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/usart_tx_scheduler.sv
// Shares one USART transmitter among NREQ byte requesters, with frame timeout
// supervision and a fixed idle gap between frames.
module usart_tx_scheduler
    import usart_pkg::*;
#(
    parameter int NREQ       = DEF_NREQ,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                   CLK,
    input  logic                   CLR,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [BYTE_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]      tx_data,
    output logic                   tx_load,
    input  logic                   tx_busy,
    input  logic                   tx_done,
    output logic [GID_W-1:0]       grant_id,
    output logic                   active,
    output logic                   timeout_err,
    input  logic                   err_clr
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t              state_q;
    logic [GID_W-1:0]    ptr_q, ptr_d;
    logic [TW-1:0]       to_cnt_q, to_cnt_d;
    logic [3:0]          gap_cnt_q, gap_cnt_d;
    logic [NREQ-1:0]     req_ready_q;
    logic [BYTE_W-1:0]   tx_data_q;
    logic                tx_load_q;
    logic [GID_W-1:0]    grant_id_q;
    logic                active_q;
    logic                err_q;

    logic [NREQ-1:0]     arb_grant;
    logic [GID_W-1:0]    arb_index;
    logic                arb_any;
    logic [BYTE_W-1:0]   sel_byte;
    logic                to_hit;
    logic                gap_done;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .index (arb_index),
        .any   (arb_any)
    );

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) sel_byte = req_data[i*BYTE_W +: BYTE_W];
        end
    end

    // Both counters saturate so a stuck transmitter can never wrap them back to zero.
    always_comb begin
        ptr_d     = (arb_index == GID_W'(NREQ - 1)) ? '0 : arb_index + 1'b1;
        to_cnt_d  = (to_cnt_q == TW'(TIMEOUT)) ? to_cnt_q : to_cnt_q + 1'b1;
        gap_cnt_d = (gap_cnt_q == 4'hF) ? gap_cnt_q : gap_cnt_q + 1'b1;
        to_hit    = (to_cnt_q >= TW'(TIMEOUT - 1));
        gap_done  = (({1'b0, gap_cnt_q} + 5'd1) >= 5'(GAP_CYCLES));
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            to_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            req_ready_q <= '0;
            tx_data_q   <= '0;
            tx_load_q   <= 1'b0;
            grant_id_q  <= '0;
            active_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            req_ready_q <= '0;
            tx_load_q   <= 1'b0;
            if (err_clr) err_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        req_ready_q <= arb_grant;
                        tx_data_q   <= sel_byte;
                        grant_id_q  <= arb_index;
                        ptr_q       <= ptr_d;
                        active_q    <= 1'b1;
                        state_q     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_load_q <= 1'b1;
                    to_cnt_q  <= '0;
                    state_q   <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY, ST_WAIT_DONE: begin
                    to_cnt_q <= to_cnt_d;
                    // A completed frame outranks a timeout landing on the same clock.
                    if (tx_done) begin
                        gap_cnt_q <= '0;
                        state_q   <= ST_GAP;
                    end else if (to_hit) begin
                        if (!err_clr) err_q <= 1'b1;
                        gap_cnt_q <= '0;
                        state_q   <= ST_GAP;
                    end else if (state_q == ST_WAIT_BUSY && tx_busy) begin
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        active_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_data     = tx_data_q;
    assign tx_load     = tx_load_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign timeout_err = err_q;

endmodule

// File: doc/usart_tx_scheduler.md
USART_TX_SCHEDULER -- requirements
Module: usart_tx_scheduler

Interface
REQ-001 SHALL take parameter NREQ, default 4, giving the number of byte requesters (2..8).
REQ-002 SHALL take parameter GAP_CYCLES, default 2, giving the idle clocks inserted between frames (0..15).
REQ-003 SHALL take parameter TIMEOUT, default 1024, giving the maximum clocks from tx_load to tx_done.
REQ-004 SHALL have port CLK, input, 1 bit: the single system clock, rising edge.
REQ-005 SHALL have port CLR, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, NREQ bits: requester i has a byte pending.
REQ-007 SHALL have port req_data, input, 8*NREQ bits: byte i occupies bits [8i+7:8i].
REQ-008 SHALL have port req_ready, output, NREQ bits: one-hot, one-cycle byte-accept strobe.
REQ-009 SHALL have port tx_data, output, 8 bits: byte presented to the USART transmitter.
REQ-010 SHALL have port tx_load, output, 1 bit: one-cycle start strobe to the transmitter.
REQ-011 SHALL have port tx_busy, input, 1 bit: transmitter shifting a frame.
REQ-012 SHALL have port tx_done, input, 1 bit: one-cycle end-of-frame (stop bit sent) pulse.
REQ-013 SHALL have port grant_id, output, 3 bits: index of the requester currently owning the transmitter.
REQ-014 SHALL have port active, output, 1 bit: a frame is in flight (states LOAD through GAP).
REQ-015 SHALL have port timeout_err, output, 1 bit: sticky flag, cleared only by err_clr or CLR.
REQ-016 SHALL have port err_clr, input, 1 bit: clears timeout_err.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, WAIT_BUSY, WAIT_DONE and GAP.
REQ-018 IDLE: when any req_valid is high, SHALL grant round-robin starting at pointer ptr, pulse req_ready[g] for one clock, capture req_data[g] into tx_data and set grant_id=g, then go to LOAD next clock.
REQ-019 SHALL set ptr to (g+1) mod NREQ on each grant; a requester that is not granted keeps req_valid and data stable.
REQ-020 LOAD: SHALL assert tx_load for exactly one clock, then go to WAIT_BUSY; the total latency from the grant clock to tx_load is 1 clock.
REQ-021 WAIT_BUSY: SHALL go to WAIT_DONE on tx_busy=1; on tx_done=1 (fast frame) it SHALL go directly to GAP.
REQ-022 WAIT_DONE: SHALL go to GAP on tx_done=1.
REQ-023 SHALL count clocks from tx_load in WAIT_BUSY/WAIT_DONE; when the count reaches TIMEOUT with no tx_done, it SHALL set timeout_err and go to GAP.
REQ-024 If tx_done and the timeout occur in the same clock, SHALL take tx_done and leave timeout_err unchanged.
REQ-025 GAP: SHALL hold for GAP_CYCLES clocks, then go to IDLE; GAP_CYCLES=0 SHALL go to IDLE on the next clock.
REQ-026 SHALL hold tx_data stable from the grant until the return to IDLE.
REQ-027 SHALL ignore req_valid outside IDLE, with req_ready low there.
REQ-028 SHALL give err_clr priority over setting timeout_err in the same clock.
REQ-029 SHALL ignore tx_done in IDLE, LOAD and GAP.
REQ-030 SHALL use counter widths $clog2(TIMEOUT+1) and 4 bits, with saturating compare (no wrap-around).

Reset
REQ-031 With CLR=1 at a clock edge, SHALL force state IDLE, ptr=0, both counters 0, and tx_data, tx_load, req_ready, grant_id, active and timeout_err to 0.
REQ-032 CLR mid-frame SHALL abort with no tx_load reissue; the dropped byte is not retransmitted.

Structure
REQ-033 Package usart_pkg SHALL hold the state enum, the byte width constant (8) and the default NREQ/GAP_CYCLES/TIMEOUT constants.
REQ-034 Round-robin selection SHALL be one sub-module, rr_arbiter (inputs req, ptr; outputs one-hot grant, index, any).

Verification
REQ-035 Single request: req_valid=0001, data 0xB1 -> req_ready[0] pulse, tx_load 1 clock later with tx_data=0xB1; tx_done -> active low after GAP_CYCLES+1 clocks.
REQ-036 Fairness: all four valid continuously -> grant order 0,1,2,3,0 with ptr wrap-around.
REQ-037 Timeout: tx_busy=1 with no tx_done -> timeout_err=1 exactly TIMEOUT clocks after tx_load; err_clr -> 0.
REQ-038 Simultaneous: tx_done and timeout in the same clock -> timeout_err stays 0; err_clr and timeout together -> stays 0.
REQ-039 Reset mid-frame: CLR asserted in WAIT_DONE -> all outputs 0 the next clock; the next grant goes to requester 0.
REQ-040 Fast frame: tx_done in WAIT_BUSY with tx_busy never high -> GAP reached, no timeout.
